// File: rtl/luzes_tx_if.sv
// Parallel word / start request in, serial LED-chain signals and frame status out.
interface luzes_tx_if #(
  parameter int NBITS = 4
);
  logic [NBITS-1:0] data;
  logic             start;
  logic             out;
  logic             sclk;
  logic             busy;
  logic             done;

  modport master (
    output data,
    output start,
    input  out,
    input  sclk,
    input  busy,
    input  done
  );

  modport slave (
    input  data,
    input  start,
    output out,
    output sclk,
    output busy,
    output done
  );
endinterface

// File: rtl/luzes_tx.sv
// Serialises a latched NBITS word, LSB first, one bit per DIV board-clock cycles,
// with a matching slow clock whose rising edge sits mid-bit for the LED shift register.
//
// state | meaning
// IDLE  | out low, waiting for start; word latched on acceptance
// ARM   | word held, waiting for the divider wrap to present bit 0
// SHIFT | one bit per wrap; the wrap after the last bit ends the frame
module luzes_tx #(
  parameter int DIV   = 50_000_000,
  parameter int NBITS = 4
) (
  input  logic       clock_placa,
  input  logic       reset,
  luzes_tx_if.slave  bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(NBITS + 1);

  localparam logic [CW-1:0] CONT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] CONT_HALF = CW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  logic [CW-1:0]    cont;
  logic             tick;
  logic             sclk_q;

  state_t           state, state_n;
  logic [NBITS-1:0] shreg, shreg_n;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic             out_q, out_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  assign tick = (cont == CONT_MAX);

  // Free-running divider; sclk is high for the second half of every bit period.
  always_ff @(posedge clock_placa or posedge reset) begin
    if (reset) begin
      cont   <= '0;
      sclk_q <= 1'b0;
    end else begin
      cont   <= tick ? '0 : cont + CW'(1);
      sclk_q <= (cont >= CONT_HALF);
    end
  end

  always_ff @(posedge clock_placa or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      out_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      bitcnt <= bitcnt_n;
      out_q  <= out_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    out_n    = out_q;
    busy_n   = busy_q;
    done_n   = 1'b0;

    unique case (state)
      IDLE: begin
        out_n  = 1'b0;
        busy_n = 1'b0;
        // A start on a tick edge still lands in ARM and waits a full period.
        if (bus.start) begin
          shreg_n = bus.data;
          busy_n  = 1'b1;
          state_n = ARM;
        end
      end

      ARM: begin
        if (tick) begin
          out_n    = shreg[0];
          shreg_n  = shreg >> 1;
          bitcnt_n = BW'(1);
          state_n  = SHIFT;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (bitcnt < BIT_LAST) begin
            out_n    = shreg[0];
            shreg_n  = shreg >> 1;
            bitcnt_n = bitcnt + BW'(1);
          end else begin
            out_n    = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b1;
            bitcnt_n = '0;
            state_n  = IDLE;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.out  = out_q;
  assign bus.sclk = sclk_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_luzes_tx.sv
// Directed bench for luzes_tx at DIV=4, NBITS=4 with a behavioural LED shift register on sclk.
module tb_luzes_tx;

  localparam int DIV = 4;
  localparam int NB  = 4;

  logic clock_placa = 1'b0;
  logic reset       = 1'b1;

  luzes_tx_if #(.NBITS(NB)) bus ();

  luzes_tx #(.DIV(DIV), .NBITS(NB)) dut (
    .clock_placa (clock_placa),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 clock_placa = ~clock_placa;

  // Bench-side divider phase, reset together with the DUT.
  int tcont;
  always @(posedge clock_placa or posedge reset) begin
    if (reset) tcont <= 0;
    else       tcont <= (tcont + 1) % DIV;
  end

  // Receiver: serial in to Q3, shifting towards Q0.
  logic [NB-1:0] rx;
  always @(posedge bus.sclk or posedge reset) begin
    if (reset) rx <= '0;
    else       rx <= {bus.out, rx[NB-1:1]};
  end

  int n_cmp = 0;
  int n_bad = 0;

  // {out, busy, done, sclk} per sample
  logic [3:0]    cap_v  [0:63];
  logic [NB-1:0] cap_rx [0:63];

  task automatic sample(input int k);
    @(negedge clock_placa);
    cap_v[k]  = {bus.out, bus.busy, bus.done, bus.sclk};
    cap_rx[k] = rx;
  endtask

  // Waits for a given divider phase, then raises start with the word.
  task automatic launch(input logic [NB-1:0] d, input int phase, output int c);
    int guard;
    guard = 0;
    @(negedge clock_placa);
    while (tcont != phase && guard < 2 * DIV) begin
      @(negedge clock_placa);
      guard++;
    end
    if (tcont != phase) begin
      n_cmp++;
      n_bad++;
      $display("FAIL phase_wait got %0d want %0d", tcont, phase);
    end
    c         = tcont;
    bus.data  = d;
    bus.start = 1'b1;
  endtask

  // Samples from the acceptance edge until the first bit appears on out.
  function automatic int lat_of(input int c);
    return (c == DIV - 1) ? DIV : (DIV - 1 - c);
  endfunction

  // {out, busy, done} for sample rel (0 = right after the acceptance edge).
  function automatic logic [2:0] frame_model(input int rel, input int lat, input logic [NB-1:0] d);
    if (rel < 0) return 3'b000;
    if (rel < lat) return 3'b010;
    if (rel < lat + NB * DIV) return {d[(rel - lat) / DIV], 2'b10};
    if (rel == lat + NB * DIV) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic sclk_model(input int c, input int k);
    return ((c + k) % DIV) >= (DIV / 2);
  endfunction

  task automatic test_reset();
    logic [3:0] want;
    bus.data  = '0;
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clock_placa);
    n_cmp++;
    if ({bus.out, bus.busy, bus.done, bus.sclk} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_hold got %b want 0000", {bus.out, bus.busy, bus.done, bus.sclk});
    end
    reset = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      @(negedge clock_placa);
      want = {3'b000, (((m - 1) % DIV) >= (DIV / 2))};
      n_cmp++;
      if ({bus.out, bus.busy, bus.done, bus.sclk} !== want) begin
        n_bad++;
        $display("FAIL reset_release m=%0d got %b want %b", m,
                 {bus.out, bus.busy, bus.done, bus.sclk}, want);
      end
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out, bus.busy, bus.done, bus.sclk} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_async got %b want 0000", {bus.out, bus.busy, bus.done, bus.sclk});
    end
    @(negedge clock_placa);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int c, lat;
    logic [3:0] want;
    launch(4'b1011, 0, c);
    lat = lat_of(c);
    for (int k = 0; k < 24; k++) begin
      sample(k);
      if (k == 0) bus.start = 1'b0;
    end
    for (int k = 0; k < 24; k++) begin
      want = {frame_model(k, lat, 4'b1011), sclk_model(c, k)};
      n_cmp++;
      if (cap_v[k] !== want) begin
        n_bad++;
        $display("FAIL basic k=%0d got %b want %b", k, cap_v[k], want);
      end
    end
    n_cmp++;
    if (cap_rx[lat + NB * DIV] !== 4'b1011) begin
      n_bad++;
      $display("FAIL basic_rx got %b want 1011", cap_rx[lat + NB * DIV]);
    end
  endtask

  task automatic test_start_while_busy();
    int c, lat, ndone;
    logic [3:0] want;
    launch(4'h5, 2, c);
    lat = lat_of(c);
    for (int k = 0; k < 28; k++) begin
      sample(k);
      if (k == 0) bus.start = 1'b0;
      if (k == lat + DIV) begin
        bus.start = 1'b1;
        bus.data  = 4'hA;
      end
      if (k == lat + DIV + 1) bus.start = 1'b0;
    end
    ndone = 0;
    for (int k = 0; k < 28; k++) begin
      want = {frame_model(k, lat, 4'h5), sclk_model(c, k)};
      if (cap_v[k][1]) ndone++;
      n_cmp++;
      if (cap_v[k] !== want) begin
        n_bad++;
        $display("FAIL busy_start k=%0d got %b want %b", k, cap_v[k], want);
      end
    end
    n_cmp++;
    if (cap_rx[lat + NB * DIV] !== 4'h5) begin
      n_bad++;
      $display("FAIL busy_start_rx got %h want 5", cap_rx[lat + NB * DIV]);
    end
    n_cmp++;
    if (ndone != 1) begin
      n_bad++;
      $display("FAIL busy_start_done_count got %0d want 1", ndone);
    end
  endtask

  task automatic test_reset_mid_frame();
    int c, lat, nbad_idle;
    logic [3:0] want;
    launch(4'b0100, 1, c);
    lat = lat_of(c);
    for (int k = 0; k <= lat + 2 * DIV; k++) begin
      sample(k);
      if (k == 0) bus.start = 1'b0;
    end
    n_cmp++;
    if (cap_v[lat + 2 * DIV][3:2] !== 2'b11) begin
      n_bad++;
      $display("FAIL midframe_pre got out,busy=%b want 11", cap_v[lat + 2 * DIV][3:2]);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out, bus.busy, bus.done, bus.sclk} !== 4'b0000) begin
      n_bad++;
      $display("FAIL midframe_async got %b want 0000", {bus.out, bus.busy, bus.done, bus.sclk});
    end
    @(negedge clock_placa);
    reset = 1'b0;
    nbad_idle = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock_placa);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) nbad_idle++;
    end
    n_cmp++;
    if (nbad_idle != 0) begin
      n_bad++;
      $display("FAIL midframe_no_done got %0d busy/done cycles want 0", nbad_idle);
    end
    launch(4'b0011, 0, c);
    lat = lat_of(c);
    for (int k = 0; k < 24; k++) begin
      sample(k);
      if (k == 0) bus.start = 1'b0;
    end
    for (int k = 0; k < 24; k++) begin
      want = {frame_model(k, lat, 4'b0011), sclk_model(c, k)};
      n_cmp++;
      if (cap_v[k] !== want) begin
        n_bad++;
        $display("FAIL after_reset k=%0d got %b want %b", k, cap_v[k], want);
      end
    end
    n_cmp++;
    if (cap_rx[lat + NB * DIV] !== 4'b0011) begin
      n_bad++;
      $display("FAIL after_reset_rx got %b want 0011", cap_rx[lat + NB * DIV]);
    end
  endtask

  task automatic test_start_on_tick();
    int c, lat, first;
    logic [3:0] want;
    launch(4'b0111, DIV - 1, c);
    lat = lat_of(c);
    for (int k = 0; k < 24; k++) begin
      sample(k);
      if (k == 0) bus.start = 1'b0;
    end
    first = -1;
    for (int k = 0; k < 24; k++) begin
      if (first < 0 && cap_v[k][3]) first = k;
      want = {frame_model(k, lat, 4'b0111), sclk_model(c, k)};
      n_cmp++;
      if (cap_v[k] !== want) begin
        n_bad++;
        $display("FAIL on_tick k=%0d got %b want %b", k, cap_v[k], want);
      end
    end
    n_cmp++;
    if (first != 4) begin
      n_bad++;
      $display("FAIL on_tick_latency got %0d want 4", first);
    end
  endtask

  task automatic test_back_to_back();
    int c, lat1, lat2, s2, n;
    logic [3:0] want;
    launch(4'b0000, 1, c);
    lat1 = lat_of(c);
    s2   = lat1 + NB * DIV + 1;
    lat2 = lat_of((c + s2) % DIV);
    n    = s2 + lat2 + NB * DIV + 3;
    for (int k = 0; k < n; k++) begin
      sample(k);
      if (k == 4) bus.data = 4'b1111;
      if (k == s2) bus.start = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      want = {frame_model(k, lat1, 4'b0000) | frame_model(k - s2, lat2, 4'b1111),
              sclk_model(c, k)};
      n_cmp++;
      if (cap_v[k] !== want) begin
        n_bad++;
        $display("FAIL b2b k=%0d got %b want %b", k, cap_v[k], want);
      end
    end
    n_cmp++;
    if (cap_rx[lat1 + NB * DIV] !== 4'b0000) begin
      n_bad++;
      $display("FAIL b2b_rx0 got %b want 0000", cap_rx[lat1 + NB * DIV]);
    end
    n_cmp++;
    if (cap_rx[s2 + lat2 + NB * DIV] !== 4'b1111) begin
      n_bad++;
      $display("FAIL b2b_rx1 got %b want 1111", cap_rx[s2 + lat2 + NB * DIV]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data  = '0;
    bus.start = 1'b0;
    test_reset();
    test_basic();
    test_start_while_busy();
    test_reset_mid_frame();
    test_start_on_tick();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
